// File: rtl/game_over_text_renderer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_over_text_renderer_pkg
// Description : Shared constants for the game-over text renderer: glyph ROM
//               letter codes, the "GAME OVER" string, glyph geometry and the
//               blink state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package game_over_text_renderer_pkg;

    // Letter codes understood by the external 8x8 glyph ROM
    localparam logic [3:0] GLYPH_G     = 4'h0;
    localparam logic [3:0] GLYPH_A     = 4'h1;
    localparam logic [3:0] GLYPH_M     = 4'h2;
    localparam logic [3:0] GLYPH_E     = 4'h3;
    localparam logic [3:0] GLYPH_O     = 4'h4;
    localparam logic [3:0] GLYPH_V     = 4'h5;
    localparam logic [3:0] GLYPH_R     = 4'h6;
    localparam logic [3:0] GLYPH_SPACE = 4'hF;

    localparam int STR_LEN    = 9;
    localparam int GLYPH_SIZE = 8;

    // "GAME OVER", index 0 is the leftmost character
    localparam logic [3:0] STR_CODES [STR_LEN] = '{
        GLYPH_G, GLYPH_A, GLYPH_M, GLYPH_E, GLYPH_SPACE,
        GLYPH_O, GLYPH_V, GLYPH_E, GLYPH_R
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_HIDE = 2'd2
    } blink_state_t;

    // Letter code for a character index; indices past the string read blank
    function automatic logic [3:0] char_code(input logic [7:0] idx);
        logic [3:0] code;
        code = GLYPH_SPACE;
        for (int i = 0; i < STR_LEN; i++) begin
            if (idx == 8'(i)) begin
                code = STR_CODES[i];
            end
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_over_text_renderer_text_blink_fsm.sv
`default_nettype none
// ============================================================================
// Module      : text_blink_fsm
// Description : IDLE/SHOW/HIDE controller for the game-over text. Counts
//               frame_start pulses and toggles SHOW<->HIDE every
//               BLINK_FRAMES frames (never hides when BLINK_FRAMES = 0).
//               Dropping i_enable returns to IDLE on the next edge and takes
//               priority over a coincident frame pulse.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_enable          - level, text requested
//               i_frame_start     - one-cycle pulse per frame
//               o_show            - state is SHOW
//               o_active          - state is SHOW or HIDE
// Revision    : 1.0 - initial release
// ============================================================================
module text_blink_fsm
    import game_over_text_renderer_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_frame_start,
    output logic o_show,
    output logic o_active
);

    localparam int c_CNT_W = (BLINK_FRAMES < 1) ? 1 : $clog2(BLINK_FRAMES + 1);

    blink_state_t         r_state;
    blink_state_t         w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 w_wrap;

    // Last count of a half-period; without blinking the state never toggles
    generate
        if (BLINK_FRAMES > 0) begin : g_blink
            localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BLINK_FRAMES - 1);
            assign w_wrap = (r_cnt == c_LAST);
        end else begin : g_no_blink
            assign w_wrap = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_show      = (r_state == ST_SHOW);
        o_active    = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (i_enable) begin
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHOW, ST_HIDE: begin
                if (!i_enable) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (i_frame_start) begin
                    if (w_wrap) begin
                        w_state_nxt = (r_state == ST_SHOW) ? ST_HIDE : ST_SHOW;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/game_over_text_renderer.sv
`default_nettype none
// ============================================================================
// Module      : game_over_text_renderer
// Description : Renders "GAME OVER" from an external registered 8x8 glyph
//               ROM at (ORIGIN_X, ORIGIN_Y), magnified by 2^SCALE_LOG2, with
//               optional frame blinking. x/y/de -> pixel_on latency is
//               3 cycles.
// Ports       : clk, rst          - pixel clock, synchronous active-high reset
//               enable            - level, text requested
//               frame_start       - one-cycle pulse per frame
//               de, x, y          - raster position from the timing generator
//               glyph_letter      - letter code to the glyph ROM (registered)
//               glyph_bitmap      - ROM bitmap, row 0 in [63:56], bit 7 left
//               pixel_on          - text pixel lit (registered)
//               active            - state is SHOW or HIDE
// Revision    : 1.0 - initial release
// ============================================================================
module game_over_text_renderer
    import game_over_text_renderer_pkg::*;
#(
    parameter int ORIGIN_X     = 256,
    parameter int ORIGIN_Y     = 224,
    parameter int SCALE_LOG2   = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        frame_start,
    input  logic        de,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    output logic [3:0]  glyph_letter,
    input  logic [63:0] glyph_bitmap,
    output logic        pixel_on,
    output logic        active
);

    localparam int c_BOX_W = (STR_LEN * GLYPH_SIZE) << SCALE_LOG2;
    localparam int c_BOX_H = GLYPH_SIZE << SCALE_LOG2;

    // One extra bit so the right/bottom bounds cannot wrap
    localparam logic [11:0] c_X_LO = 12'(ORIGIN_X);
    localparam logic [11:0] c_X_HI = 12'(ORIGIN_X + c_BOX_W);
    localparam logic [10:0] c_Y_LO = 11'(ORIGIN_Y);
    localparam logic [10:0] c_Y_HI = 11'(ORIGIN_Y + c_BOX_H);

    logic        w_show;
    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic [7:0]  w_char;
    logic [2:0]  w_col;
    logic [2:0]  w_row;
    logic        w_in_box;
    logic        w_vis;

    logic [2:0]  r_row1, r_col1, r_row2, r_col2;
    logic        r_vld1, r_vld2;

    text_blink_fsm #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (enable),
        .i_frame_start (frame_start),
        .o_show        (w_show),
        .o_active      (active)
    );

    // Box-relative offsets; values outside the box are don't-care
    assign w_dx   = x - c_X_LO[10:0];
    assign w_dy   = {1'b0, y} - c_Y_LO;
    assign w_char = 8'(w_dx >> (SCALE_LOG2 + 3));
    assign w_col  = 3'(w_dx >> SCALE_LOG2);
    assign w_row  = 3'(w_dy >> SCALE_LOG2);

    assign w_in_box = de
                   && ({1'b0, x} >= c_X_LO) && ({1'b0, x} < c_X_HI)
                   && ({1'b0, y} >= c_Y_LO) && ({1'b0, y} < c_Y_HI);

    // SHOW is sampled here, so in-flight pixels keep the gating they entered with
    assign w_vis = w_in_box && w_show;

    always_ff @(posedge clk) begin
        if (rst) begin
            glyph_letter <= GLYPH_SPACE;
            r_row1       <= '0;
            r_col1       <= '0;
            r_vld1       <= 1'b0;
            r_row2       <= '0;
            r_col2       <= '0;
            r_vld2       <= 1'b0;
            pixel_on     <= 1'b0;
        end else begin
            // Stage 1: address the ROM
            glyph_letter <= w_vis ? char_code(w_char) : GLYPH_SPACE;
            r_row1       <= w_row;
            r_col1       <= w_col;
            r_vld1       <= w_vis;
            // Stage 2: wait out the ROM's own register
            r_row2       <= r_row1;
            r_col2       <= r_col1;
            r_vld2       <= r_vld1;
            // Stage 3: bit (7-row)*8 + (7-col) is simply {~row, ~col}
            pixel_on     <= r_vld2 && glyph_bitmap[{~r_row2, ~r_col2}];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_over_text_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_over_text_renderer
// Description : Self-checking bench. A frame/box arithmetic model predicts
//               glyph_letter, pixel_on and active for a blinking build and a
//               BLINK_FRAMES=0 build every cycle; directed probes pin the
//               model with hand-derived literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_over_text_renderer;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        frame_start;
    logic        de;
    logic [10:0] x;
    logic [9:0]  y;
    logic [3:0]  gl1, gl2;
    logic [63:0] bm1, bm2;
    logic        po1, po2, act1, act2;

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;

    int str_codes [9] = '{0, 1, 2, 3, 15, 4, 5, 3, 6};

    game_over_text_renderer #(
        .ORIGIN_X(256), .ORIGIN_Y(224), .SCALE_LOG2(2), .BLINK_FRAMES(30)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
        .de(de), .x(x), .y(y), .glyph_letter(gl1), .glyph_bitmap(bm1),
        .pixel_on(po1), .active(act1)
    );

    game_over_text_renderer #(
        .ORIGIN_X(256), .ORIGIN_Y(224), .SCALE_LOG2(2), .BLINK_FRAMES(0)
    ) dut_nb (
        .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
        .de(de), .x(x), .y(y), .glyph_letter(gl2), .glyph_bitmap(bm2),
        .pixel_on(po2), .active(act2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] font64(input int code);
        case (code)
            0:       return 64'h3C66C0CEC6663E00; // G
            1:       return 64'h183C66667E666600; // A
            2:       return 64'hC6EEFED6C6C6C600; // M
            3:       return 64'h7E60607C60607E00; // E
            4:       return 64'h3C66666666663C00; // O
            5:       return 64'h66666666663C1800; // V
            6:       return 64'h7C66667C786C6600; // R
            default: return 64'h0;
        endcase
    endfunction

    // Registered glyph ROM
    always @(posedge clk) begin
        bm1 <= font64(int'(gl1));
        bm2 <= font64(int'(gl2));
    end

    // ---------------- behavioural model ----------------
    bit         m_active;
    int         m_frames;
    logic [3:0] e1_letter, e2_letter;
    bit         e1_s1, e1_s2, e1_pix, e2_s1, e2_s2, e2_pix;

    function automatic bit in_box_f(input bit d, input int xi, input int yi);
        return d && xi >= 256 && xi < 544 && yi >= 224 && yi < 256;
    endfunction

    function automatic bit show_f(input int bf);
        if (!m_active) return 1'b0;
        if (bf == 0) return 1'b1;
        return ((m_frames / bf) % 2) == 0;
    endfunction

    function automatic int letter_f(input bit vis, input int xi);
        if (!vis) return 15;
        return str_codes[(xi - 256) / 32];
    endfunction

    function automatic bit pix_f(input bit vis, input int xi, input int yi);
        logic [63:0] f;
        int row, col;
        if (!vis) return 1'b0;
        row = ((yi - 224) / 4) % 8;
        col = ((xi - 256) / 4) % 8;
        f   = font64(letter_f(1'b1, xi));
        return f[63 - row * 8 - col];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_active  <= 1'b0;
            m_frames  <= 0;
            e1_letter <= 4'hF; e1_s1 <= 1'b0; e1_s2 <= 1'b0; e1_pix <= 1'b0;
            e2_letter <= 4'hF; e2_s1 <= 1'b0; e2_s2 <= 1'b0; e2_pix <= 1'b0;
        end else begin
            e1_letter <= 4'(letter_f(in_box_f(de, int'(x), int'(y)) && show_f(30), int'(x)));
            e1_s1     <= pix_f(in_box_f(de, int'(x), int'(y)) && show_f(30), int'(x), int'(y));
            e1_s2     <= e1_s1;
            e1_pix    <= e1_s2;
            e2_letter <= 4'(letter_f(in_box_f(de, int'(x), int'(y)) && show_f(0), int'(x)));
            e2_s1     <= pix_f(in_box_f(de, int'(x), int'(y)) && show_f(0), int'(x), int'(y));
            e2_s2     <= e2_s1;
            e2_pix    <= e2_s2;
            if (!enable) begin
                m_active <= 1'b0;
                m_frames <= 0;
            end else if (!m_active) begin
                m_active <= 1'b1;
                m_frames <= 0;
            end else if (frame_start) begin
                m_frames <= m_frames + 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("model_letter", 64'(gl1), 64'(e1_letter));
            check("model_pixel", 64'(po1), 64'(e1_pix));
            check("model_active", 64'(act1), 64'(m_active));
            check("model_nb_letter", 64'(gl2), 64'(e2_letter));
            check("model_nb_pixel", 64'(po2), 64'(e2_pix));
            check("model_nb_active", 64'(act2), 64'(m_active));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic probe(input string n, input bit d, input int xi, input int yi,
                         input logic [3:0] el, input bit ep, input bit ep_nb);
        de = d;
        x  = 11'(xi);
        y  = 10'(yi);
        @(negedge clk);
        check({n, "_letter"}, 64'(gl1), 64'(el));
        @(negedge clk);
        @(negedge clk);
        check({n, "_pixel"}, 64'(po1), 64'(ep));
        check({n, "_nb_pixel"}, 64'(po2), 64'(ep_nb));
        de = 1'b0;
    endtask

    task automatic pulse();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; frame_start = 1'b0; de = 1'b0; x = '0; y = '0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        check("rst_letter", 64'(gl1), 64'hF);
        check("rst_pixel", 64'(po1), 64'h0);
        check("rst_active", 64'(act1), 64'h0);
        rst = 1'b0;

        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("en_active", 64'(act1), 64'h1);

        probe("g_r0c2", 1'b1, 264, 224, 4'h0, 1'b1, 1'b1);
        probe("g_r0c0", 1'b1, 256, 224, 4'h0, 1'b0, 1'b0);
        for (int i = 256; i < 260; i++) probe("g_col0_rep", 1'b1, i, 224, 4'h0, 1'b0, 1'b0);
        for (int i = 264; i < 268; i++) probe("g_col2_rep", 1'b1, i, 224, 4'h0, 1'b1, 1'b1);
        probe("a_r0c3", 1'b1, 300, 224, 4'h1, 1'b1, 1'b1);
        probe("m_r3c0", 1'b1, 320, 236, 4'h2, 1'b1, 1'b1);
        probe("space", 1'b1, 384, 230, 4'hF, 1'b0, 1'b0);
        probe("right_out", 1'b1, 544, 224, 4'hF, 1'b0, 1'b0);
        probe("bottom_out", 1'b1, 264, 256, 4'hF, 1'b0, 1'b0);
        probe("de_low", 1'b0, 264, 224, 4'hF, 1'b0, 1'b0);

        // Blink: 30 frames hidden, 30 more shown again
        repeat (30) pulse();
        probe("hidden", 1'b1, 264, 224, 4'hF, 1'b0, 1'b1);
        check("hidden_active", 64'(act1), 64'h1);
        check("hidden_nb_letter", 64'(gl2), 64'h0);
        repeat (30) pulse();
        probe("reshown", 1'b1, 264, 224, 4'h0, 1'b1, 1'b1);

        // Leave the counter mid-period, then drop enable together with a frame pulse
        repeat (5) pulse();
        de = 1'b1; x = 11'd264; y = 10'd224;
        @(negedge clk);
        enable = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("dis_active", 64'(act1), 64'h0);
        probe("dis_pixel", 1'b1, 264, 224, 4'hF, 1'b0, 1'b0);
        enable = 1'b1;
        @(negedge clk);
        check("reen_active", 64'(act1), 64'h1);
        repeat (29) pulse();
        probe("cnt_restart", 1'b1, 264, 224, 4'h0, 1'b1, 1'b1);
        pulse();
        probe("cnt_hide", 1'b1, 264, 224, 4'hF, 1'b0, 1'b1);
        repeat (30) pulse();

        // Reset in the middle of a lit glyph
        de = 1'b1; x = 11'd264; y = 10'd224;
        repeat (3) @(negedge clk);
        check("pre_rst_pixel", 64'(po1), 64'h1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_pixel", 64'(po1), 64'h0);
        check("mid_rst_letter", 64'(gl1), 64'hF);
        check("mid_rst_active", 64'(act1), 64'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_flush", 64'(po1), 64'h0);
        end
        repeat (3) @(negedge clk);
        check("post_rst_relit", 64'(po1), 64'h1);

        de = 1'b0;
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
